// File: rtl/temp_sched_pkg.sv
// Shared types and constants for the LM75 temperature read scheduler.
package temp_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_BUSY,
        ST_BACKOFF
    } sched_state_t;

    localparam logic [6:0] LM75_ADDR_DEF = 7'h48;
    localparam logic [7:0] LM75_PTR_TEMP = 8'h00;
    localparam int         F_OFFSET      = 32;

endpackage

// File: rtl/temp_c2f.sv
// Combinational signed Celsius-to-Fahrenheit conversion: f = (c*9)/5 + 32,
// truncating toward zero. The parent registers the result.
module temp_c2f
    import temp_sched_pkg::*;
(
    input  logic [7:0] temp_c,
    output logic [9:0] temp_f
);

    localparam logic signed [11:0] OFFSET = 12'(F_OFFSET);

    logic signed [11:0] c_ext;

    assign c_ext = {{4{temp_c[7]}}, temp_c};

    // 12-bit signed covers -128*9 .. 127*9; SV signed division truncates toward zero.
    assign temp_f = 10'((c_ext * 12'sd9) / 12'sd5 + OFFSET);

endmodule

// File: rtl/temp_read_scheduler.sv
// Periodic LM75 temperature read sequencer: schedules reads, retries failures and
// publishes Celsius/Fahrenheit. Define TEMP_SCHED_TIMEOUT_EN to add a BUSY watchdog.
module temp_read_scheduler
    import temp_sched_pkg::*;
#(
    parameter int         PERIOD_CYCLES  = 2_500_000,
    parameter logic [6:0] DEV_ADDR       = LM75_ADDR_DEF,
    parameter int         MAX_RETRY      = 3,
    parameter int         BACKOFF_CYCLES = 16,
    parameter int         TIMEOUT_CYCLES = 200_000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        enable,
    input  logic        trig,
    output logic        mst_start,
    output logic [6:0]  mst_dev_addr,
    output logic [7:0]  mst_ptr,
    output logic        mst_abort,
    input  logic        mst_busy,
    input  logic        mst_done,
    input  logic        mst_ack_err,
    input  logic [15:0] mst_rdata,
    output logic [7:0]  temp_c,
    output logic [9:0]  temp_f,
    output logic        valid,
    output logic        upd,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int BW = $clog2(BACKOFF_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 2);

    sched_state_t  state, state_d;
    logic [PW-1:0] period_cnt;
    logic [BW-1:0] backoff_cnt;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_nxt;
    logic          pending;
    logic          start_d;
    logic          good;
    logic          bad;
    logic          retry_more;
    logic          sample_begin;
    logic          timeout;
    logic [9:0]    f_conv;
    logic          unused_bits;

    assign mst_dev_addr = DEV_ADDR;
    assign mst_ptr      = LM75_PTR_TEMP;
    assign retry_nxt    = retry_cnt + RW'(1);
    assign retry_more   = (retry_nxt <= RW'(MAX_RETRY));
    // WAIT always holds retry_cnt == 0, so entering ISSUE from WAIT is a first attempt.
    assign sample_begin = (state == ST_WAIT) && (state_d == ST_ISSUE);

    temp_c2f u_c2f (
        .temp_c (mst_rdata[15:8]),
        .temp_f (f_conv)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= ST_IDLE;
        else             state <= state_d;
    end

    // NOTE: every signal driven here gets a default first; a path without an assignment would infer a latch.
    always_comb begin
        state_d = state;
        start_d = 1'b0;
        good    = 1'b0;
        bad     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable || trig || pending) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pending || (enable && period_cnt == '0)) state_d = ST_ISSUE;
                else if (!enable)                            state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (!mst_busy) begin
                    start_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mst_done && !mst_ack_err) begin
                    good    = 1'b1;
                    state_d = ST_WAIT;
                end else if (mst_done || timeout) begin
                    bad     = 1'b1;
                    state_d = retry_more ? ST_BACKOFF : ST_WAIT;
                end
            end
            ST_BACKOFF: begin
                if (backoff_cnt == '0) state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            period_cnt  <= '0;
            backoff_cnt <= '0;
            retry_cnt   <= '0;
            pending     <= 1'b0;
            mst_start   <= 1'b0;
            upd         <= 1'b0;
            temp_c      <= '0;
            temp_f      <= '0;
            valid       <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
        end else begin
            mst_start <= start_d;
            upd       <= good;

            if (state != ST_IDLE && period_cnt != '0) period_cnt <= period_cnt - PW'(1);
            if (sample_begin)                         period_cnt <= PW'(PERIOD_CYCLES - 1);

            // A trig in the same cycle as the clear must survive as the next request.
            if (trig)              pending <= 1'b1;
            else if (sample_begin) pending <= 1'b0;

            if (state == ST_BACKOFF && backoff_cnt != '0) backoff_cnt <= backoff_cnt - BW'(1);

            if (good) begin
                temp_c    <= mst_rdata[15:8];
                temp_f    <= f_conv;
                valid     <= 1'b1;
                err       <= 1'b0;
                retry_cnt <= '0;
            end

            if (bad) begin
                if (retry_more) begin
                    retry_cnt   <= retry_nxt;
                    // The single ISSUE cycle completes the idle gap before the retry start.
                    backoff_cnt <= BW'(BACKOFF_CYCLES - 2);
                end else begin
                    err       <= 1'b1;
                    retry_cnt <= '0;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

`ifdef TEMP_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;

    assign timeout     = (state == ST_BUSY) && !mst_done && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign unused_bits = ^mst_rdata[7:0];

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            to_cnt    <= '0;
            mst_abort <= 1'b0;
        end else begin
            mst_abort <= timeout;
            if (state == ST_BUSY && !timeout) to_cnt <= to_cnt + TW'(1);
            else                              to_cnt <= '0;
        end
    end
`else
    assign timeout     = 1'b0;
    assign mst_abort   = 1'b0;
    assign unused_bits = ^{mst_rdata[7:0], 1'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_temp_read_scheduler.sv
// Directed bench for temp_read_scheduler with a simple I2C master/slave model.
// Timeout section runs only when TEMP_SCHED_TIMEOUT_EN is defined.
module tb_temp_read_scheduler;

    localparam int PERIOD    = 1000;
    localparam int BACKOFF   = 16;
    localparam int TIMEOUT   = 300;
    localparam int SLAVE_LAT = 10;

    logic        clk;
    logic        CPU_RESETN;
    logic        enable;
    logic        trig;
    logic        mst_start;
    logic [6:0]  mst_dev_addr;
    logic [7:0]  mst_ptr;
    logic        mst_abort;
    logic        mst_busy;
    logic        mst_done;
    logic        mst_ack_err;
    logic [15:0] mst_rdata;
    logic [7:0]  temp_c;
    logic [9:0]  temp_f;
    logic        valid;
    logic        upd;
    logic        err;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Slave control, written only by the main sequence.
    logic [15:0] slave_word  = 16'h1E00;
    int          nack_until  = 0;
    logic        always_nack = 1'b0;
    logic        hang        = 1'b0;

    // Event logs, written only by the slave/monitor process.
    int start_q[$];
    int done_q[$];
    int upd_q[$];
    int abort_q[$];

    temp_read_scheduler #(
        .PERIOD_CYCLES  (PERIOD),
        .DEV_ADDR       (7'h48),
        .MAX_RETRY      (3),
        .BACKOFF_CYCLES (BACKOFF),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (CPU_RESETN),
        .enable       (enable),
        .trig         (trig),
        .mst_start    (mst_start),
        .mst_dev_addr (mst_dev_addr),
        .mst_ptr      (mst_ptr),
        .mst_abort    (mst_abort),
        .mst_busy     (mst_busy),
        .mst_done     (mst_done),
        .mst_ack_err  (mst_ack_err),
        .mst_rdata    (mst_rdata),
        .temp_c       (temp_c),
        .temp_f       (temp_f),
        .valid        (valid),
        .upd          (upd),
        .err          (err),
        .err_cnt      (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Master/slave model: logs DUT pulses and answers each start after SLAVE_LAT cycles.
    initial begin : slave_model
        int lat;
        lat         = 0;
        mst_busy    = 1'b0;
        mst_done    = 1'b0;
        mst_ack_err = 1'b0;
        mst_rdata   = 16'h0000;
        forever begin
            @(negedge clk);
            if (mst_start === 1'b1) start_q.push_back(cyc);
            if (upd === 1'b1)       upd_q.push_back(cyc);
            if (mst_abort === 1'b1) abort_q.push_back(cyc);
            mst_done    = 1'b0;
            mst_ack_err = 1'b0;
            if (mst_abort === 1'b1) begin
                mst_busy = 1'b0;
                lat      = 0;
            end else if (mst_busy) begin
                if (!hang) begin
                    lat--;
                    if (lat == 0) begin
                        mst_busy    = 1'b0;
                        mst_done    = 1'b1;
                        mst_ack_err = always_nack || ((start_q.size() - 1) < nack_until);
                        mst_rdata   = slave_word;
                        done_q.push_back(cyc);
                    end
                end
            end else if (mst_start === 1'b1) begin
                mst_busy = 1'b1;
                lat      = SLAVE_LAT;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [9:0] f10(input int v);
        return v[9:0];
    endfunction

    task automatic wait_upd(input string tag, input int budget);
        int n0;
        int k;
        n0 = upd_q.size();
        k  = 0;
        while (upd_q.size() == n0 && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(upd_q.size() > n0), 1);
    endtask

    task automatic wait_start(input string tag, input int n0, input int budget);
        int k;
        k = 0;
        while (start_q.size() <= n0 && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(start_q.size() > n0), 1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_temp_c"},    temp_c,    0);
        check({pfx, "_temp_f"},    temp_f,    0);
        check({pfx, "_valid"},     valid,     0);
        check({pfx, "_upd"},       upd,       0);
        check({pfx, "_err"},       err,       0);
        check({pfx, "_err_cnt"},   err_cnt,   0);
        check({pfx, "_mst_start"}, mst_start, 0);
        check({pfx, "_mst_abort"}, mst_abort, 0);
    endtask

    initial begin : main
        int rel_cyc;
        int ns;
        int nd;
        int nu;
        int k;

        CPU_RESETN = 1'b0;
        enable     = 1'b1;
        trig       = 1'b0;
        repeat (3) step();

        check_reset_outputs("rst");
        check("dev_addr", mst_dev_addr, 7'h48);
        check("ptr",      mst_ptr,      8'h00);

        // First read: start three cycles after reset release.
        @(negedge clk);
        CPU_RESETN = 1'b1;
        rel_cyc    = cyc;
        wait_start("first_start_seen", 0, 20);
        check("first_start_cycle", start_q[0], rel_cyc + 3);
        wait_upd("first_upd_seen", 40);
        check("upd_latency", upd_q[0], done_q[0] + 1);
        check("t30_c",     temp_c, 8'd30);
        check("t30_f",     temp_f, f10(86));
        check("t30_valid", valid,  1);
        check("t30_err",   err,    0);

        // Scheduled samples, including extremes and a truncation case.
        slave_word = 16'hD800;
        wait_upd("m40_upd_seen", 1500);
        check("period_interval", start_q[1] - start_q[0], PERIOD);
        check("m40_c", temp_c, 8'hD8);
        check("m40_f", temp_f, f10(-40));

        slave_word = 16'h7D00;
        wait_upd("p125_upd_seen", 1500);
        check("p125_c", temp_c, 8'd125);
        check("p125_f", temp_f, f10(257));

        slave_word = 16'hFF00;
        wait_upd("m1_upd_seen", 1500);
        check("m1_c", temp_c, 8'hFF);
        check("m1_f", temp_f, f10(31));

        // Two NACKs then ACK: three starts, each retry 17 cycles after the failing done.
        ns         = start_q.size();
        nd         = done_q.size();
        nack_until = ns + 2;
        slave_word = 16'h1900;
        wait_upd("retry_upd_seen", 1500);
        check("retry_starts", start_q.size() - ns, 3);
        check("retry1_gap",   start_q[ns + 1] - done_q[nd],     BACKOFF + 1);
        check("retry2_gap",   start_q[ns + 2] - done_q[nd + 1], BACKOFF + 1);
        check("retry_c",      temp_c, 8'd25);
        check("retry_f",      temp_f, f10(77));
        check("retry_err",    err,    0);

        // Permanent NACK: four starts per sample, err raised, temperature held.
        ns          = start_q.size();
        nu          = upd_q.size();
        always_nack = 1'b1;
        k = 0;
        while (err !== 1'b1 && k < 1500) begin
            step();
            k++;
        end
        check("fail1_err",     err,     1);
        check("fail1_err_cnt", err_cnt, 1);
        check("fail1_starts",  start_q.size() - ns, 4);
        check("fail1_no_upd",  upd_q.size() - nu,   0);
        check("fail1_hold_c",  temp_c, 8'd25);
        check("fail1_hold_f",  temp_f, f10(77));
        check("fail1_valid",   valid,  1);
        k = 0;
        while (err_cnt !== 8'd2 && k < 1500) begin
            step();
            k++;
        end
        check("fail2_err_cnt", err_cnt, 2);
        check("fail2_starts",  start_q.size() - ns, 8);

        always_nack = 1'b0;
        slave_word  = 16'h8000;
        wait_upd("recover_upd_seen", 1500);
        check("recover_err",     err,     0);
        check("recover_err_cnt", err_cnt, 2);
        check("m128_c",          temp_c,  8'h80);
        check("m128_f",          temp_f,  f10(-198));

        // Three trigs during BUSY collapse into one extra read right after completion.
        ns         = start_q.size();
        slave_word = 16'h7F00;
        wait_start("trig_base_start", ns, 1500);
        step();
        step();
        repeat (3) begin
            trig = 1'b1;
            step();
            trig = 1'b0;
            step();
        end
        wait_upd("trig_base_upd", 40);
        check("p127_c", temp_c, 8'd127);
        check("p127_f", temp_f, f10(260));
        nd         = done_q.size();
        slave_word = 16'h0000;
        wait_start("trig_extra_start", ns + 1, 50);
        check("trig_extra_gap", start_q[ns + 1] - done_q[nd - 1], 3);
        wait_upd("trig_extra_upd", 40);
        check("zero_f", temp_f, f10(32));
        repeat (200) step();
        check("trig_single_extra", start_q.size() - ns, 2);

        // enable low: no scheduled reads; one trig gives exactly one read.
        enable = 1'b0;
        ns     = start_q.size();
        repeat (1200) step();
        check("disabled_no_start", start_q.size() - ns, 0);
        slave_word = 16'h0100;
        trig = 1'b1;
        step();
        trig = 1'b0;
        wait_upd("oneshot_upd", 60);
        check("p1_c", temp_c, 8'd1);
        check("p1_f", temp_f, f10(33));
        repeat (1200) step();
        check("oneshot_starts", start_q.size() - ns, 1);

`ifdef TEMP_SCHED_TIMEOUT_EN
        // Stuck transaction: abort after TIMEOUT cycles in BUSY, then the retry path.
        enable = 1'b1;
        hang   = 1'b1;
        ns     = start_q.size();
        wait_start("to_start", ns, 1500);
        k = 0;
        while (abort_q.size() == 0 && k < TIMEOUT + 20) begin
            step();
            k++;
        end
        hang = 1'b0;
        check("to_abort_seen",  32'(abort_q.size() > 0), 1);
        check("to_abort_cycle", abort_q[0] - start_q[ns], TIMEOUT);
        wait_start("to_retry_start", ns + 1, 50);
        check("to_retry_gap", start_q[ns + 1] - abort_q[0], BACKOFF);
        wait_upd("to_recover_upd", 40);
        check("to_err", err, 0);
`endif

        // Reset pulse mid-BUSY returns every output to reset values.
        enable = 1'b1;
        ns     = start_q.size();
        wait_start("rst_busy_start", ns, 1500);
        step();
        step();
        CPU_RESETN = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        check_reset_outputs("midrst_hold");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
